// File: rtl/ex_muldiv_unit_if.sv
// Issue/result handshake bundle between decode, the M-extension unit and writeback.
interface ex_muldiv_unit_if #(
   parameter int XLEN       = 64,
   parameter int REG_ADDR_W = 5
) ();
   logic                  InValid;
   logic                  InReady;
   logic [6:0]            OpCodeIn;
   logic [2:0]            Funct3In;
   logic [XLEN-1:0]       Rs1ReadDataIn;
   logic [XLEN-1:0]       Rs2ReadDataIn;
   logic [REG_ADDR_W-1:0] RdAddrIn;
   logic                  OutValid;
   logic                  OutReady;
   logic [XLEN-1:0]       RdWriteDataOut;
   logic [REG_ADDR_W-1:0] RdAddrOut;
   logic                  RdWriteEnableOut;
   logic                  BusyOut;

   modport slave (
      input  InValid, OpCodeIn, Funct3In, Rs1ReadDataIn, Rs2ReadDataIn, RdAddrIn, OutReady,
      output InReady, OutValid, RdWriteDataOut, RdAddrOut, RdWriteEnableOut, BusyOut
   );

   modport master (
      output InValid, OpCodeIn, Funct3In, Rs1ReadDataIn, Rs2ReadDataIn, RdAddrIn, OutReady,
      input  InReady, OutValid, RdWriteDataOut, RdAddrOut, RdWriteEnableOut, BusyOut
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: MSB-first shift-add multiply, restoring divide.
// state | meaning
// IDLE  | ready for a new op
// CALC  | one iteration per cycle, then a final sign fix-up/result-register cycle
// DONE  | result held until the consumer takes it
module ex_muldiv_unit #(
   parameter int XLEN       = 64,
   parameter int REG_ADDR_W = 5
) (
   input logic              Clk,
   input logic              RstN,
   input logic              FlushIn,
   ex_muldiv_unit_if.slave  bus
);

   localparam int CW = $clog2(XLEN);
   localparam logic [6:0]      OPC_W = 7'b0111011;
   localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = ~XLEN'(32'h7fff_ffff);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  fin_q, fin_d;
   logic                  spec_q, spec_d;
   logic                  w_q, w_d;
   logic [2:0]            f3_q, f3_d;
   logic                  neg_q, neg_d;
   logic                  neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]       a_q, a_d;
   logic [XLEN-1:0]       b_q, b_d;
   logic [2*XLEN-1:0]     prod_q, prod_d;
   logic [XLEN-1:0]       quo_q, quo_d;
   logic [XLEN-1:0]       rem_q, rem_d;
   logic [XLEN-1:0]       res_q, res_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;

   function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] v, input logic w);
      return w ? XLEN'($signed(v[31:0])) : v;
   endfunction

   logic            in_w, sgn_a, sgn_b, in_div, a_neg, b_neg, b_zero, ovf, special;
   logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;

   always_comb begin
      in_w   = (bus.OpCodeIn == OPC_W) && (XLEN == 64);
      sgn_a  = (bus.Funct3In == 3'b001) || (bus.Funct3In == 3'b010) ||
               (bus.Funct3In == 3'b100) || (bus.Funct3In == 3'b110);
      sgn_b  = (bus.Funct3In == 3'b001) || (bus.Funct3In == 3'b100) ||
               (bus.Funct3In == 3'b110);
      in_div = bus.Funct3In[2];
      if (in_w) begin
         a_ext = sgn_a ? XLEN'($signed(bus.Rs1ReadDataIn[31:0])) : XLEN'(bus.Rs1ReadDataIn[31:0]);
         b_ext = sgn_b ? XLEN'($signed(bus.Rs2ReadDataIn[31:0])) : XLEN'(bus.Rs2ReadDataIn[31:0]);
      end else begin
         a_ext = bus.Rs1ReadDataIn;
         b_ext = bus.Rs2ReadDataIn;
      end
      a_neg   = sgn_a & a_ext[XLEN-1];
      b_neg   = sgn_b & b_ext[XLEN-1];
      a_mag   = a_neg ? -a_ext : a_ext;
      b_mag   = b_neg ? -b_ext : b_ext;
      b_zero  = (b_ext == '0);
      ovf     = in_div && !bus.Funct3In[0] && (a_ext == (in_w ? MIN_W : MIN_X)) && (b_ext == '1);
      special = in_div && (b_zero || ovf);
   end

   // Iteration datapath and final result select, both from registered state.
   logic [XLEN-1:0]   addend;
   logic [XLEN:0]     rem_sh;
   logic              ge;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, raw_res;

   always_comb begin
      addend = b_q[cnt_q] ? a_q : '0;
      rem_sh = {rem_q, a_q[cnt_q]};
      ge     = (rem_sh >= {1'b0, b_q});
      prod_s = neg_q ? -prod_q : prod_q;
      quo_s  = neg_q ? -quo_q : quo_q;
      rem_s  = neg_rem_q ? -rem_q : rem_q;
      if (f3_q[2])
         raw_res = f3_q[1] ? rem_s : quo_s;
      else if (f3_q[1:0] == 2'b00)
         raw_res = prod_s[XLEN-1:0];
      else
         raw_res = w_q ? XLEN'(prod_s >> 32) : prod_s[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fin_d     = fin_q;
      spec_d    = spec_q;
      w_d       = w_q;
      f3_d      = f3_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      a_d       = a_q;
      b_d       = b_q;
      prod_d    = prod_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      res_d     = res_q;
      rd_d      = rd_q;
      if (FlushIn) begin
         state_d = IDLE;
         fin_d   = 1'b0;
         spec_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.InValid) begin
                  w_d       = in_w;
                  f3_d      = bus.Funct3In;
                  rd_d      = bus.RdAddrIn;
                  a_d       = a_mag;
                  b_d       = b_mag;
                  neg_d     = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  prod_d    = '0;
                  quo_d     = '0;
                  rem_d     = '0;
                  cnt_d     = in_w ? CW'(31) : CW'(XLEN-1);
                  fin_d     = special;
                  spec_d    = special;
                  state_d   = CALC;
                  // Divide-by-zero and signed overflow skip the iterations entirely.
                  if (in_div && b_zero)
                     res_d = wfix(bus.Funct3In[1] ? a_ext : '1, in_w);
                  else if (ovf)
                     res_d = wfix(bus.Funct3In[1] ? '0 : a_ext, in_w);
               end
            end
            CALC: begin
               if (fin_q) begin
                  if (!spec_q)
                     res_d = wfix(raw_res, w_q);
                  fin_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  if (f3_q[2]) begin
                     rem_d = ge ? XLEN'(rem_sh - {1'b0, b_q}) : rem_sh[XLEN-1:0];
                     quo_d = (quo_q << 1) | XLEN'(ge);
                  end else begin
                     prod_d = (prod_q << 1) + {{XLEN{1'b0}}, addend};
                  end
                  if (cnt_q == '0)
                     fin_d = 1'b1;
                  else
                     cnt_d = cnt_q - CW'(1);
               end
            end
            DONE: begin
               if (bus.OutReady)
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!RstN) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         fin_q     <= 1'b0;
         spec_q    <= 1'b0;
         w_q       <= 1'b0;
         f3_q      <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         prod_q    <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         res_q     <= '0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fin_q     <= fin_d;
         spec_q    <= spec_d;
         w_q       <= w_d;
         f3_q      <= f3_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         a_q       <= a_d;
         b_q       <= b_d;
         prod_q    <= prod_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         res_q     <= res_d;
         rd_q      <= rd_d;
      end
   end

   assign bus.InReady          = (state_q == IDLE);
   assign bus.OutValid         = (state_q == DONE);
   assign bus.BusyOut          = (state_q != IDLE);
   assign bus.RdWriteDataOut   = res_q;
   assign bus.RdAddrOut        = rd_q;
   assign bus.RdWriteEnableOut = (state_q == DONE) && (rd_q != '0);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: results, latency, backpressure, flush and reset.
module tb_ex_muldiv_unit;

   logic Clk = 1'b0;
   logic RstN;
   logic FlushIn;
   int   n_tests = 0;
   int   n_fail  = 0;

   localparam logic [6:0] OPX = 7'b0110011;
   localparam logic [6:0] OPW = 7'b0111011;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   ex_muldiv_unit_if #(.XLEN(64), .REG_ADDR_W(5)) bus ();

   ex_muldiv_unit #(.XLEN(64), .REG_ADDR_W(5)) dut (
      .Clk     (Clk),
      .RstN    (RstN),
      .FlushIn (FlushIn),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [6:0] opc, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
      @(negedge Clk);
      chk("in_ready_idle", 64'(bus.InReady), 64'd1);
      bus.InValid       = 1'b1;
      bus.OpCodeIn      = opc;
      bus.Funct3In      = f3;
      bus.Rs1ReadDataIn = a;
      bus.Rs2ReadDataIn = b;
      bus.RdAddrIn      = rd;
      @(negedge Clk);
      bus.InValid = 1'b0;
   endtask

   // Counts edges after the accept edge until OutValid; InReady must stay low meanwhile.
   task automatic wait_out(output int lat, output logic rdy_low);
      lat     = 0;
      rdy_low = 1'b1;
      while (!bus.OutValid && lat < 200) begin
         if (bus.InReady || !bus.BusyOut) rdy_low = 1'b0;
         @(negedge Clk);
         lat++;
      end
      if (bus.InReady) rdy_low = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp, input int exp_lat);
      int   lat;
      logic rdy_low;
      issue(opc, f3, a, b, rd);
      wait_out(lat, rdy_low);
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_data"}, bus.RdWriteDataOut, exp);
      chk({tag, "_rd"}, 64'(bus.RdAddrOut), 64'(rd));
      chk({tag, "_we"}, 64'(bus.RdWriteEnableOut), (rd != 5'd0) ? 64'd1 : 64'd0);
      chk({tag, "_inready_low"}, 64'(rdy_low), 64'd1);
      @(negedge Clk);
      chk({tag, "_consumed"}, 64'(bus.OutValid), 64'd0);
   endtask

   initial begin
      int   lat;
      logic rdy_low;
      logic stable;
      logic seen;

      RstN              = 1'b0;
      FlushIn           = 1'b0;
      bus.InValid       = 1'b0;
      bus.OpCodeIn      = OPX;
      bus.Funct3In      = 3'b000;
      bus.Rs1ReadDataIn = '0;
      bus.Rs2ReadDataIn = '0;
      bus.RdAddrIn      = '0;
      bus.OutReady      = 1'b1;
      repeat (2) @(negedge Clk);
      chk("rst_in_ready", 64'(bus.InReady), 64'd1);
      chk("rst_out_valid", 64'(bus.OutValid), 64'd0);
      chk("rst_busy", 64'(bus.BusyOut), 64'd0);
      chk("rst_data", bus.RdWriteDataOut, 64'd0);
      chk("rst_rd", 64'(bus.RdAddrOut), 64'd0);
      chk("rst_we", 64'(bus.RdWriteEnableOut), 64'd0);
      RstN = 1'b1;

      do_op("mul",       OPX, 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 65);
      do_op("mulhu",     OPX, 3'b011, ONES, ONES, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      do_op("mulhsu",    OPX, 3'b010, ONES, 64'd2, 5'd0, ONES, 65);
      do_op("mulw",      OPW, 3'b000, 64'h7FFF_FFFF, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, 33);
      do_op("div_ovf",   OPX, 3'b100, 64'h8000_0000_0000_0000, ONES, 5'd8, 64'h8000_0000_0000_0000, 1);
      do_op("rem_ovf",   OPX, 3'b110, 64'h8000_0000_0000_0000, ONES, 5'd9, 64'd0, 1);
      do_op("divu_zero", OPX, 3'b101, 64'h1234, 64'd0, 5'd10, ONES, 1);
      do_op("remu_zero", OPX, 3'b111, 64'd9, 64'd0, 5'd11, 64'd9, 1);
      do_op("div_neg",   OPX, 3'b100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd12, 64'hFFFF_FFFF_FFFF_FFF2, 65);
      do_op("rem_neg",   OPX, 3'b110, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      do_op("divu",      OPX, 3'b101, 64'd100, 64'd7, 5'd13, 64'd14, 65);
      do_op("divw",      OPW, 3'b100, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd14, 64'hFFFF_FFFF_FFFF_FFFD, 33);
      do_op("remw",      OPW, 3'b110, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd15, ONES, 33);

      // Backpressure: result held for 10 cycles while a new op is offered.
      bus.OutReady = 1'b0;
      issue(OPX, 3'b000, 64'd6, 64'd7, 5'd3);
      wait_out(lat, rdy_low);
      chk("bp_lat", 64'(lat), 64'd65);
      stable            = 1'b1;
      bus.InValid       = 1'b1;
      bus.Funct3In      = 3'b101;
      bus.Rs1ReadDataIn = 64'd50;
      bus.Rs2ReadDataIn = 64'd5;
      repeat (10) begin
         if (!bus.OutValid || bus.RdWriteDataOut !== 64'd42 || bus.InReady || bus.RdAddrOut !== 5'd3)
            stable = 1'b0;
         @(negedge Clk);
      end
      chk("bp_stable", 64'(stable), 64'd1);
      chk("bp_data_end", bus.RdWriteDataOut, 64'd42);
      bus.InValid  = 1'b0;
      bus.OutReady = 1'b1;
      @(negedge Clk);
      chk("bp_consumed", 64'(bus.OutValid), 64'd0);
      chk("bp_not_accepted", 64'(bus.BusyOut), 64'd0);

      // Flush together with InValid in IDLE: nothing accepted.
      bus.InValid  = 1'b1;
      bus.Funct3In = 3'b000;
      FlushIn      = 1'b1;
      @(negedge Clk);
      bus.InValid = 1'b0;
      FlushIn     = 1'b0;
      chk("flush_idle_busy", 64'(bus.BusyOut), 64'd0);

      // Flush around iteration 20 of a multiply.
      issue(OPX, 3'b000, 64'd5, 64'd5, 5'd4);
      repeat (20) @(negedge Clk);
      chk("flush_pre_busy", 64'(bus.BusyOut), 64'd1);
      FlushIn = 1'b1;
      @(negedge Clk);
      FlushIn = 1'b0;
      chk("flush_busy", 64'(bus.BusyOut), 64'd0);
      chk("flush_in_ready", 64'(bus.InReady), 64'd1);
      seen = 1'b0;
      repeat (80) begin
         @(negedge Clk);
         if (bus.OutValid) seen = 1'b1;
      end
      chk("flush_no_result", 64'(seen), 64'd0);

      // Reset while holding a result in DONE.
      bus.OutReady = 1'b0;
      issue(OPX, 3'b000, 64'd3, 64'd5, 5'd6);
      wait_out(lat, rdy_low);
      chk("rstdone_lat", 64'(lat), 64'd65);
      chk("rstdone_data", bus.RdWriteDataOut, 64'd15);
      RstN = 1'b0;
      @(negedge Clk);
      RstN = 1'b1;
      chk("rstdone_valid", 64'(bus.OutValid), 64'd0);
      chk("rstdone_busy", 64'(bus.BusyOut), 64'd0);
      chk("rstdone_data0", bus.RdWriteDataOut, 64'd0);
      chk("rstdone_rd0", 64'(bus.RdAddrOut), 64'd0);
      bus.OutReady = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge Clk);
         if (bus.OutValid) seen = 1'b1;
      end
      chk("rstdone_no_result", 64'(seen), 64'd0);

      do_op("mul_after", OPX, 3'b000, 64'd3, 64'd4, 5'd1, 64'd12, 65);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle RV64M execute unit. Sits beside the single-cycle integer execute stage and takes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus the W variants.
- Upstream decode issues only M-extension ops (funct7 = 0000001) over a valid/ready handshake.
- Returns the rd write data over a second valid/ready handshake, using iterative shift-add multiplication and restoring division.

Parameters:
- XLEN, 64, datapath width. Legal values are 32 and 64. W ops are legal only when XLEN = 64.
- REG_ADDR_W, 5, width of the register-file address.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- RstN  input  1  synchronous active-low reset.
- FlushIn  input  1  kill the in-flight op; synchronous.
- InValid  input  1  the operation below is valid.
- InReady  output  1  unit can accept an operation.
- OpCodeIn  input  7  0110011 = XLEN op, 0111011 = W op.
- Funct3In  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Rs1ReadDataIn  input  XLEN  operand a.
- Rs2ReadDataIn  input  XLEN  operand b.
- RdAddrIn  input  REG_ADDR_W  destination register.
- OutValid  output  1  result valid.
- OutReady  input  1  consumer accepts the result.
- RdWriteDataOut  output  XLEN  result.
- RdAddrOut  output  REG_ADDR_W  latched destination register.
- RdWriteEnableOut  output  1  equals OutValid & (RdAddrOut != 0).
- BusyOut  output  1  high in CALC or DONE.

Behaviour:
- Reset: when RstN = 0 at a rising Clk edge:
  - state goes to IDLE;
  - OutValid = 0, InReady = 1, BusyOut = 0;
  - RdWriteDataOut = 0, RdAddrOut = 0, all internal registers = 0.
  - Reset mid-operation discards the op; no result is produced.
- IDLE state:
  - InReady = 1.
  - Accept when InValid & InReady & !FlushIn at edge t. Latch op, operands and RdAddrIn.
  - Then go to CALC with N = 32 for W ops, else XLEN.
  - Special case, DIV/DIVU/REM/REMU with divisor = 0: skip CALC and go to DONE. Result is all-ones for DIV/DIVU and the dividend for REM/REMU.
  - Special case, signed overflow (dividend = most-negative, divisor = -1): go straight to DONE. DIV result = dividend, REM result = 0.
- CALC state:
  - InReady = 0.
  - Operands are converted to magnitudes. Signedness: MULH, DIV and REM treat both operands as signed; MULHSU treats a as signed and b as unsigned; the rest are unsigned.
  - One iteration per cycle with a counter from N-1 down to 0.
  - Multiply: 2N-bit shift-add accumulator.
  - Divide: restoring; one quotient bit per cycle, with the partial remainder kept N+1 bits wide.
  - After the last iteration, apply the sign fix-up:
    - product sign is a^b, for the signed operands;
    - quotient sign is a^b;
    - remainder sign is the sign of the dividend.
  - Then register the result and go to DONE.
- Result selection:
  - MUL takes the product's low N bits.
  - MULH/MULHSU/MULHU take the high N bits.
  - W ops: operands are the low 32 bits, sign- or zero-extended per op. The result is the low 32 bits sign-extended to 64.
- Latency:
  - Normal ops: OutValid rises at cycle t+N+1, i.e. 65 cycles for XLEN ops and 33 for W ops.
  - Special cases: OutValid rises at t+1.
- DONE state:
  - OutValid = 1, InReady = 0.
  - RdWriteDataOut and RdAddrOut are held stable until OutValid & OutReady at an edge, then the unit goes to IDLE.
  - No new op is accepted in the handshake cycle; the next accept is possible the following cycle.
- Flush:
  - In any state, FlushIn = 1 at an edge sends the unit to IDLE with OutValid = 0.
  - A flush in DONE drops the result, even if OutReady is high in the same cycle.
  - Flush and InValid together in IDLE: flush wins and nothing is accepted.
  - Reset has priority over flush.
- OutReady is ignored outside DONE. InValid is ignored outside IDLE, and the upstream stage must hold its op stable while InReady = 0.
- RdWriteEnableOut is 0 when RdAddrOut = 0; the result is still handshaken normally.

Test Plan:
- MUL, a=7, b=-3, XLEN=64, rd=5, OutReady=1: RdWriteDataOut=0xFFFFFFFFFFFFFFEB. OutValid rises exactly 65 cycles after accept. RdAddrOut=5, RdWriteEnableOut=1. InReady=0 throughout CALC/DONE.
- MULHU, a=b=0xFFFFFFFFFFFFFFFF: result 0xFFFFFFFFFFFFFFFE. MULHSU with a=-1, b=2: result 0xFFFFFFFFFFFFFFFF.
- DIV, a=0x8000000000000000, b=-1: quotient 0x8000000000000000 one cycle after accept. REM on the same operands gives 0. DIVU by 0 gives all-ones, REMU a=9 by 0 gives 9, both with 1-cycle latency.
- DIVW, a=0x00000000FFFFFFF9 (-7 as 32-bit), b=2: result 0xFFFFFFFFFFFFFFFD after 33 cycles. REMW on the same operands gives 0xFFFFFFFFFFFFFFFF.
- Backpressure: hold OutReady=0 for 10 cycles in DONE. OutValid and RdWriteDataOut must stay stable, InValid must not be accepted, and the result is consumed in the cycle OutReady rises.
- Flush at CALC iteration 20, then RstN=0 in DONE: both return to IDLE with OutValid=0 and produce no result. The next MUL 3*4 gives 12.
